minx16_dbus_bridge: RTL
=======================

# minx16_dbus_bridge

Downstream slave for the Minx16 CPU's multiplexed address/data bus (AD, ALE, DLE, STB, RD, WR, RDY). It demultiplexes each bus cycle, issues one request on a simple synchronous memory port, and returns read data plus a one-cycle RDY to the CPU. A timeout keeps a silent memory from hanging the CPU. The block sits between the CPU's bus pins and user-area SRAM/peripheral logic, all in the CPU clock domain.

## Interface
Parameters:
- ADDR_W, 15: memory word-address width; mem_addr_o = latched byte address[ADDR_W:1].
- TIMEOUT, 15: maximum number of cycles waiting for mem_ack_i before a forced completion; legal range 1..255.

Ports:
- clk  in  1  clock, shared with the CPU.
- reset  in  1  synchronous, active-high.
- ad_i  in  16  AD bus as driven by the CPU.
- ad_o  out  16  read data driven back to the CPU.
- ad_oe_o  out  1  high while the bridge drives AD.
- ale_i  in  1  address latch enable.
- dle_i  in  1  data phase enable.
- stb_i  in  2  byte-lane strobes; bit0 = AD[7:0], bit1 = AD[15:8].
- rd_i  in  1  read strobe.
- wr_i  in  1  write strobe.
- rdy_o  out  1  cycle-complete pulse to the CPU.
- mem_req_o  out  1  memory request, held until acknowledged.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word address.
- mem_wdata_o  out  16  write data.
- mem_be_o  out  2  byte enables (latched stb).
- mem_ack_i  in  1  one-cycle acknowledge; on reads mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  16  read data.
- err_o  out  1  sticky error flag (timeout or protocol error); cleared only by reset.
- busy_o  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, REQ, DONE, TURN.
- IDLE: when ale_i=1, latch ad_i into addr_q and go to ADDR.
- ADDR: wait for dle_i together with rd_i or wr_i. Latch stb_i into be_q.
  - On a write, also latch ad_i into wdata_q.
  - If stb_i=2'b00 (null cycle), skip the memory access and go to DONE with rdata_q=16'h0000.
  - Otherwise go to REQ.
  - rd_i and wr_i high together: set err_o, treat as a null cycle.
- REQ: mem_req_o=1, with mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o stable.
  - On mem_ack_i: capture mem_rdata_i (reads), go to DONE.
  - Timeout counter reaches TIMEOUT with no ack: rdata_q=16'hFFFF, set err_o, go to DONE.
- DONE: rdy_o=1 for exactly one cycle. On reads, ad_oe_o=1 and ad_o=rdata_q. Go to TURN.
- TURN: ad_oe_o=0. Stay until rd_i=0 and wr_i=0, then go to IDLE.
- ale_i=1 in any state other than IDLE: ignored, sets err_o.
- Byte lanes: mem_be_o=be_q. On reads the bridge drives all 16 bits of ad_o regardless of stb.
- Reset values: rdy_o, ad_oe_o, mem_req_o, mem_we_o, err_o, busy_o = 0; ad_o, mem_addr_o, mem_wdata_o, mem_be_o = 0; state = IDLE; counter = 0.

## Timing
- All outputs are registered except mem_* address/data/be, which are driven straight from latched registers (stable for the whole of REQ).
- Zero-wait read: ale@T0, rd+dle sampled @T1, mem_req_o high @T2, mem_ack_i @T2, rdy_o + ad_oe_o @T3, AD released @T4.
- Minimum cycle: 4 clocks ale-to-release. Each wait cycle of memory adds one clock.
- Timeout: mem_req_o stays high for exactly TIMEOUT cycles; rdy_o follows in the next cycle. The counter restarts at 0 on every REQ entry.
- mem_ack_i outside REQ: ignored.
- mem_ack_i in the same cycle as timeout expiry: the ack wins, err_o is not set.
- Reset mid-cycle (any state): on the next edge, go to IDLE with all outputs at reset values, so AD is released within one clock. err_o clears.
- TURN guarantees at least one cycle with ad_oe_o=0 before any new DONE, so the bus never has two drivers.

## Structure
- Package minx16_dbus_pkg: state enum (IDLE, ADDR, REQ, DONE, TURN), constants RDATA_TIMEOUT=16'hFFFF and RDATA_NULL=16'h0000.
- Optional sub-module minx16_dbus_timeout: 8-bit down-counter with load/enable/expired outputs. Everything else stays in one module.
- Top-level pin muxing of the ad_oe_o polarity to io_oeb is done by the integrator, not by this block.

## Test plan
- Zero-wait write: ale with AD=16'h1234, then wr+dle with AD=16'hBEEF, stb=2'b11, ack in the first REQ cycle -> mem_addr_o=15'h091A, mem_wdata_o=16'hBEEF, mem_be_o=2'b11, rdy_o one cycle at T3, err_o=0.
- Read with 3 wait states: address 16'h0040, mem_rdata_i=16'hA5C3 on the 4th REQ cycle -> rdy_o and ad_oe_o high together for one cycle with ad_o=16'hA5C3, AD released the next cycle.
- Timeout: TIMEOUT=15, memory never acks -> mem_req_o high for exactly 15 cycles, then rdy_o with ad_o=16'hFFFF, err_o=1 and staying 1.
- Null cycle and protocol errors: stb=2'b00 read -> no mem_req_o, rdy_o with ad_o=0. Second ale during REQ -> err_o=1, current transaction still completes normally.
- Reset in REQ and in DONE -> next cycle mem_req_o=0, ad_oe_o=0, rdy_o=0, busy_o=0, err_o=0. A following clean read completes normally.
- Back-to-back cycles with rd held 2 extra cycles after rdy -> the bridge stays in TURN until rd drops. A new ale accepted in IDLE, with no overlap of ad_oe_o.

Source files
------------

// File: rtl/minx16_dbus_pkg.sv
// Shared types and constants for the Minx16 data-bus bridge.
package minx16_dbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StReq,
        StDone,
        StTurn
    } state_e;

    localparam logic [15:0] RDATA_TIMEOUT = 16'hFFFF;
    localparam logic [15:0] RDATA_NULL    = 16'h0000;

endpackage

// File: rtl/minx16_dbus_timeout.sv
// 8-bit down-counter bounding how long the bridge waits for a memory acknowledge.
module minx16_dbus_timeout (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'd0);

endmodule

// File: rtl/minx16_dbus_bridge.sv
// Minx16 multiplexed AD bus slave: demuxes one bus cycle into a single memory
// request and returns read data with a one-cycle RDY pulse.
module minx16_dbus_bridge
    import minx16_dbus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ad_i,
    output logic [15:0]       ad_o,
    output logic              ad_oe_o,
    input  logic              ale_i,
    input  logic              dle_i,
    input  logic [1:0]        stb_i,
    input  logic              rd_i,
    input  logic              wr_i,
    output logic              rdy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic [1:0]        mem_be_o,
    input  logic              mem_ack_i,
    input  logic [15:0]       mem_rdata_i,
    output logic              err_o,
    output logic              busy_o
);

    state_e state_q, state_d;

    logic [ADDR_W:1] addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [1:0]      be_q, be_d;
    logic            we_q, we_d;
    logic            rd_q, rd_d;
    logic            err_q, err_d;

    logic            rdy_q, ad_oe_q, mem_req_q, busy_q;
    logic [15:0]     ad_q;

    logic            tmo_load, tmo_en, tmo_expired;

    minx16_dbus_timeout u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmo_load),
        .load_val_i (8'(TIMEOUT - 1)),
        .en_i       (tmo_en),
        .expired_o  (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        we_d     = we_q;
        rd_d     = rd_q;
        err_d    = err_q;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;

        // A fresh ALE is only legal between bus cycles.
        if (ale_i && (state_q != StIdle)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (ale_i) begin
                    addr_d  = ad_i[ADDR_W:1];
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (dle_i && (rd_i || wr_i)) begin
                    be_d = stb_i;
                    we_d = wr_i & ~rd_i;
                    // Conflicting strobes never drive AD back, to avoid fighting the CPU.
                    rd_d = rd_i & ~wr_i;
                    if (wr_i) begin
                        wdata_d = ad_i;
                    end
                    if (rd_i && wr_i) begin
                        err_d   = 1'b1;
                        rdata_d = RDATA_NULL;
                        state_d = StDone;
                    end else if (stb_i == 2'b00) begin
                        rdata_d = RDATA_NULL;
                        state_d = StDone;
                    end else begin
                        tmo_load = 1'b1;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                tmo_en = 1'b1;
                if (mem_ack_i) begin
                    if (rd_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = StDone;
                end else if (tmo_expired) begin
                    rdata_d = RDATA_TIMEOUT;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StTurn;
            end
            StTurn: begin
                if (!rd_i && !wr_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus-facing outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
            be_q      <= 2'b00;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            ad_oe_q   <= 1'b0;
            ad_q      <= 16'h0000;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            rdy_q     <= (state_d == StDone);
            ad_oe_q   <= (state_d == StDone) && rd_d;
            ad_q      <= ((state_d == StDone) && rd_d) ? rdata_d : 16'h0000;
            mem_req_q <= (state_d == StReq);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign ad_o        = ad_q;
    assign ad_oe_o     = ad_oe_q;
    assign rdy_o       = rdy_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule
